load_ext_unit: RTL and testbench

Load-side counterpart of the store byte-enable path in the multicycle CPU datapath. It takes a load request (byte address, access size, sign flag), performs one word read on the data-memory port with a ready handshake, and extracts the addressed byte or halfword from the returned word. It then sign- or zero-extends that value to 32 bits and presents it to the register-file write-back mux with a one-cycle valid pulse. It sits between the control FSM's MEM state and the data memory, alongside the byte-enable generator used for stores.

---
 rtl/load_ext_unit_pkg.sv | 23 ++
 rtl/load_ext_unit_ldext.sv | 34 +++
 rtl/load_ext_unit.sv | 95 +++++++++
 tb/tb_load_ext_unit.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/load_ext_unit_pkg.sv
// Shared definitions for the load path: access-size codes, FSM states and
// the alignment/legality check used when a load request is accepted.
package load_ext_unit_pkg;

  localparam logic [1:0] WORDop = 2'b00;
  localparam logic [1:0] HALFop = 2'b01;
  localparam logic [1:0] BYTEop = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_READ = 2'b01,
    S_DONE = 2'b10,
    S_ERR  = 2'b11
  } state_t;

  // 2'b11 is unused; words need addr[1:0]==0 and halfwords need addr[0]==0.
  function automatic logic access_bad(input logic [1:0] op, input logic [1:0] a);
    access_bad = (op == 2'b11) ||
                 ((op == WORDop) && (a != 2'b00)) ||
                 ((op == HALFop) && a[0]);
  endfunction

endpackage

// File: rtl/load_ext_unit_ldext.sv
// Combinational lane extraction and sign/zero extension of a loaded word.
// Lanes are little-endian, matching the store byte enables.
module ldext
  import load_ext_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  a,
  input  logic [1:0]  op,
  input  logic        sign,
  output logic [31:0] ext
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'h00;
    h = 16'h0000;
    ext = word;
    case (a)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      default: b = word[31:24];
    endcase
    h = a[1] ? word[31:16] : word[15:0];
    case (op)
      BYTEop: ext = sign ? {{24{b[7]}}, b} : {24'h000000, b};
      HALFop: ext = sign ? {{16{h[15]}}, h} : {16'h0000, h};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/load_ext_unit.sv
// Load unit: one handshaked word read per request, then lane extraction and
// extension into a registered result with a one-cycle valid or error pulse.
module load_ext_unit
  import load_ext_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [1:0]  op,
  input  logic        sign,
  output logic        busy,
  output logic        mem_rd,
  output logic [29:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] dout,
  output logic        dout_valid,
  output logic        err,
  output state_t      dbg_state
);

  // Handshake: a read is in flight while mem_rd=1; the first cycle with
  // mem_ready=1 completes it and mem_rdata is taken in that same cycle.
  // mem_ready outside READ and req outside IDLE are ignored.

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic [1:0]    lat_a;
  logic [1:0]    lat_op;
  logic          lat_sign;
  logic [CW-1:0] cnt;
  logic [31:0]   ext;

  ldext u_ldext (
    .word (mem_rdata),
    .a    (lat_a),
    .op   (lat_op),
    .sign (lat_sign),
    .ext  (ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Ready wins over timeout when both happen in the last allowed cycle.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (req) state_nx = access_bad(op, addr[1:0]) ? S_ERR : S_READ;
      S_READ: begin
        if (mem_ready)            state_nx = S_DONE;
        else if (cnt == CNT_LAST) state_nx = S_ERR;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_a    <= 2'b00;
      lat_op   <= WORDop;
      lat_sign <= 1'b0;
      mem_addr <= '0;
      cnt      <= '0;
      dout     <= '0;
    end else begin
      if (state == S_IDLE && req) begin
        lat_a    <= addr[1:0];
        lat_op   <= op;
        lat_sign <= sign;
        mem_addr <= addr[31:2];
        cnt      <= '0;
      end
      if (state == S_READ) begin
        cnt <= cnt + 1'b1;
        if (mem_ready) dout <= ext;
      end
    end
  end

  assign busy       = (state != S_IDLE);
  assign mem_rd     = (state == S_READ);
  assign dout_valid = (state == S_DONE);
  assign err        = (state == S_ERR);
  assign dbg_state  = state;

endmodule

// File: tb/tb_load_ext_unit.sv
// Directed bench for load_ext_unit: hand-computed vectors, an expected-result
// queue for completed loads, and a single summary line.
module tb_load_ext_unit;
  import load_ext_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0]  op = WORDop;
  logic        sign = 1'b0;
  logic        busy, mem_rd, dout_valid, err;
  logic [29:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] dout;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  load_ext_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .op(op), .sign(sign),
    .busy(busy), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .dout(dout), .dout_valid(dout_valid), .err(err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue a request at the falling edge; it is accepted at the next rising edge.
  task automatic issue(input logic [31:0] a, input logic [1:0] o, input logic s);
    req = 1'b1; addr = a; op = o; sign = s;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
  endtask

  // Good load: ready after 'waits' wait cycles; checks mem side and result.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] o,
                         input logic s, input logic [31:0] rdata, input int waits,
                         input logic [31:0] exp_dout, input logic [29:0] exp_maddr,
                         input int exp_busy);
    int busy_cnt;
    logic [31:0] e;
    exp_q.push_back(exp_dout);
    issue(a, o, s);
    busy_cnt = 0;
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'(exp_maddr));
    for (int k = 0; k <= waits; k++) begin
      check({tag, "_mem_rd"}, 32'(mem_rd), 32'd1);
      if (busy) busy_cnt++;
      mem_rdata = (k == waits) ? rdata : 32'hDEAD_BEEF;
      mem_ready = (k == waits);
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    if (busy) busy_cnt++;
    check({tag, "_valid"}, 32'(dout_valid), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd0);
    if (dout_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_dout"}, dout, e);
    end
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, busy, dout_valid}, 32'd0);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
  endtask

  // Rejected access: err next cycle, no read, dout untouched.
  task automatic do_bad(input string tag, input logic [31:0] a, input logic [1:0] o,
                        input logic [31:0] exp_dout);
    issue(a, o, 1'b0);
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    check({tag, "_dout"}, dout, exp_dout);
    @(negedge clk);
    check({tag, "_after"}, {29'd0, err, busy, mem_rd}, 32'd0);
  endtask

  initial begin
    int rd_cnt;
    int guard;

    #12;
    check("reset_outs", {27'd0, busy, mem_rd, dout_valid, err, 1'b0}, 32'd0);
    check("reset_maddr", 32'(mem_addr), 32'd0);
    check("reset_dout", dout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_load("byte_sx", 32'h1003, BYTEop, 1'b1, 32'h80FF_1234, 0, 32'hFFFF_FF80, 30'h400, 2);
    do_load("half_zx", 32'h0002, HALFop, 1'b0, 32'hBEEF_0001, 3, 32'h0000_BEEF, 30'h0, 5);
    do_load("byte1_zx", 32'h0011, BYTEop, 1'b0, 32'h1122_C344, 1, 32'h0000_00C3, 30'h4, 3);
    do_load("half0_sx", 32'h0020, HALFop, 1'b1, 32'h0000_8001, 0, 32'hFFFF_8001, 30'h8, 2);
    do_load("word_sx", 32'h0104, WORDop, 1'b1, 32'h8765_4321, 2, 32'h8765_4321, 30'h41, 4);

    do_bad("mis_word", 32'h0006, WORDop, 32'h8765_4321);
    do_bad("mis_half", 32'h0001, HALFop, 32'h8765_4321);
    do_bad("bad_op", 32'h0000, 2'b11, 32'h8765_4321);

    // Timeout: mem_ready held low.
    issue(32'h0040, WORDop, 1'b0);
    rd_cnt = 0;
    guard = 0;
    while (!err && guard < 20) begin
      if (mem_rd) rd_cnt++;
      @(negedge clk);
      guard++;
    end
    check("to_err", 32'(err), 32'd1);
    check("to_rd_cycles", 32'(rd_cnt), 32'd4);
    check("to_dout", dout, 32'h8765_4321);
    @(negedge clk);
    check("to_idle", {30'd0, busy, err}, 32'd0);
    do_load("after_to", 32'h0202, BYTEop, 1'b1, 32'h0055_0000, 0, 32'h0000_0055, 30'h80, 2);

    // Ready exactly in the last allowed READ cycle.
    do_load("ready_last", 32'h0008, WORDop, 1'b0, 32'hCAFE_F00D, 3, 32'hCAFE_F00D, 30'h2, 5);

    // Reset during READ.
    issue(32'h0010, WORDop, 1'b0);
    check("rst_pre_rd", 32'(mem_rd), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_outs", {29'd0, busy, mem_rd, dout_valid}, 32'd0);
    check("rst_dout", dout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_load("post_rst", 32'h0000, WORDop, 1'b0, 32'h1234_5678, 0, 32'h1234_5678, 30'h0, 2);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
